reloj_timer_sequencer: RTL and testbench

Avalon-MM master controller that owns the interval timer in the alarm-clock system. It programs the timer's period and control registers after reset and re-programs them on a time set. It services each timer interrupt by clearing the timer status and advancing a binary time-of-day counter (hours, minutes, seconds). It sits between the timer slave and the display/alarm logic, and optionally raises an alarm output.

---
 rtl/reloj_timer_sequencer_if.sv | 25 ++
 rtl/reloj_timer_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_reloj_timer_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reloj_timer_sequencer_if.sv
// Avalon-MM write-only link between the sequencer and the interval timer.
// Timer level interrupt travels back on the same bundle.
interface reloj_timer_sequencer_if;
   logic [2:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic        tmr_irq;

   modport master (
      output tmr_address,
      output tmr_chipselect,
      output tmr_write_n,
      output tmr_writedata,
      input  tmr_irq
   );

   modport slave (
      input  tmr_address,
      input  tmr_chipselect,
      input  tmr_write_n,
      input  tmr_writedata,
      output tmr_irq
   );
endinterface

// File: rtl/reloj_timer_sequencer.sv
// Timer programming, interrupt servicing and time-of-day counting.
// Optional alarm ring logic is compiled in with RELOJ_SEQ_ALARM_EN.
module reloj_timer_sequencer #(
   parameter logic [31:0] PERIOD_M1 = 32'h2FAF07F,
   parameter int          RING_SECS = 60
) (
   input  logic                      clk,
   input  logic                      reset,
   reloj_timer_sequencer_if.master   tmr,
   input  logic                      set_time,
   input  logic [4:0]                set_hour,
   input  logic [5:0]                set_min,
   input  logic                      alarm_en,
   input  logic [4:0]                alarm_hour,
   input  logic [5:0]                alarm_min,
   input  logic                      alarm_ack,
   output logic [4:0]                hour,
   output logic [5:0]                minute,
   output logic [5:0]                second,
   output logic                      tick,
   output logic                      ready,
   output logic                      ring
);

   typedef enum logic [2:0] {
      S_INIT_PL,
      S_INIT_PH,
      S_INIT_CTRL,
      S_IDLE,
      S_ACK,
      S_COUNT
   } state_t;

   state_t      r_state;
   logic [2:0]  r_addr;
   logic        r_cs;
   logic        r_wr_n;
   logic [15:0] r_wdata;
   logic [4:0]  r_hour;
   logic [5:0]  r_min;
   logic [5:0]  r_sec;
   logic        r_tick;
   logic        r_ready;

   logic        w_set_ok;
   logic [4:0]  w_nhour;
   logic [5:0]  w_nmin;
   logic [5:0]  w_nsec;

   assign w_set_ok = set_time && (set_hour <= 5'd23) && (set_min <= 6'd59);

   always_comb begin
      w_nsec  = r_sec + 6'd1;
      w_nmin  = r_min;
      w_nhour = r_hour;
      if (r_sec == 6'd59) begin
         w_nsec = 6'd0;
         if (r_min == 6'd59) begin
            w_nmin  = 6'd0;
            w_nhour = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
         end else begin
            w_nmin = r_min + 6'd1;
         end
      end
   end

   // Bus registers are loaded on the edge that leaves each write state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_INIT_PL;
         r_addr  <= 3'd0;
         r_cs    <= 1'b0;
         r_wr_n  <= 1'b1;
         r_wdata <= 16'd0;
         r_hour  <= 5'd0;
         r_min   <= 6'd0;
         r_sec   <= 6'd0;
         r_tick  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_addr  <= 3'd0;
         r_cs    <= 1'b0;
         r_wr_n  <= 1'b1;
         r_wdata <= 16'd0;
         r_tick  <= 1'b0;
         r_ready <= (r_state == S_IDLE) || (r_state == S_ACK) ||
                    (r_state == S_COUNT);
         if (w_set_ok) begin
            r_hour  <= set_hour;
            r_min   <= set_min;
            r_sec   <= 6'd0;
            r_ready <= 1'b0;
            r_state <= S_INIT_PL;
         end else begin
            unique case (r_state)
               S_INIT_PL: begin
                  r_cs    <= 1'b1;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 3'd2;
                  r_wdata <= PERIOD_M1[15:0];
                  r_state <= S_INIT_PH;
               end
               S_INIT_PH: begin
                  r_cs    <= 1'b1;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 3'd3;
                  r_wdata <= PERIOD_M1[31:16];
                  r_state <= S_INIT_CTRL;
               end
               S_INIT_CTRL: begin
                  r_cs    <= 1'b1;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 3'd1;
                  r_wdata <= 16'h0007;
                  r_state <= S_IDLE;
               end
               S_IDLE: begin
                  if (tmr.tmr_irq) begin
                     r_cs    <= 1'b1;
                     r_wr_n  <= 1'b0;
                     r_state <= S_ACK;
                  end
               end
               S_ACK: begin
                  r_tick  <= 1'b1;
                  r_state <= S_COUNT;
               end
               S_COUNT: begin
                  r_hour  <= w_nhour;
                  r_min   <= w_nmin;
                  r_sec   <= w_nsec;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_INIT_PL;
            endcase
         end
      end
   end

   assign tmr.tmr_address    = r_addr;
   assign tmr.tmr_chipselect = r_cs;
   assign tmr.tmr_write_n    = r_wr_n;
   assign tmr.tmr_writedata  = r_wdata;
   assign hour   = r_hour;
   assign minute = r_min;
   assign second = r_sec;
   assign ready  = r_ready;
   // A set_time landing on the COUNT cycle suppresses that tick.
   assign tick   = r_tick && !w_set_ok;

`ifdef RELOJ_SEQ_ALARM_EN
   localparam logic [5:0] LP_RING = 6'(RING_SECS);

   logic       r_ring;
   logic [5:0] r_ring_cnt;
   logic       w_upd;
   logic       w_hit;
   logic       w_expire;

   assign w_upd    = (r_state == S_COUNT) && !w_set_ok;
   assign w_hit    = w_upd && alarm_en && (w_nsec == 6'd0) &&
                     (w_nhour == alarm_hour) && (w_nmin == alarm_min);
   assign w_expire = w_upd && r_ring && ((r_ring_cnt + 6'd1) == LP_RING);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ring     <= 1'b0;
         r_ring_cnt <= 6'd0;
      end else if (alarm_ack || !alarm_en || w_set_ok || w_expire) begin
         r_ring     <= 1'b0;
         r_ring_cnt <= 6'd0;
      end else if (w_hit) begin
         r_ring     <= 1'b1;
         r_ring_cnt <= 6'd0;
      end else if (w_upd && r_ring) begin
         r_ring_cnt <= r_ring_cnt + 6'd1;
      end
   end

   assign ring = r_ring;
`else
   logic w_unused;
   assign w_unused = &{1'b0, alarm_en, alarm_hour, alarm_min, alarm_ack};
   assign ring     = 1'b0;
`endif

endmodule

// File: tb/tb_reloj_timer_sequencer.sv
// Directed bench for reloj_timer_sequencer: vector table for the
// power-up and first interrupts, hand sequences for multi-cycle cases.
module tb_reloj_timer_sequencer;

`ifdef RELOJ_SEQ_ALARM_EN
   localparam int ALM = 1;
`else
   localparam int ALM = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       set_time = 1'b0;
   logic [4:0] set_hour = 5'd0;
   logic [5:0] set_min = 6'd0;
   logic       alarm_en = 1'b0;
   logic [4:0] alarm_hour = 5'd0;
   logic [5:0] alarm_min = 6'd0;
   logic       alarm_ack = 1'b0;
   logic [4:0] hour;
   logic [5:0] minute;
   logic [5:0] second;
   logic       tick;
   logic       ready;
   logic       ring;

   int n_run = 0;
   int n_fail = 0;
   int n_ticks = 0;
   int t0;

   always #5 clk = ~clk;

   reloj_timer_sequencer_if bus();

   reloj_timer_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .tmr        (bus),
      .set_time   (set_time),
      .set_hour   (set_hour),
      .set_min    (set_min),
      .alarm_en   (alarm_en),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .alarm_ack  (alarm_ack),
      .hour       (hour),
      .minute     (minute),
      .second     (second),
      .tick       (tick),
      .ready      (ready),
      .ring       (ring)
   );

   always @(posedge clk) if (tick === 1'b1) n_ticks++;

   typedef struct {
      logic        irq;
      logic        cs;
      logic        wr_n;
      logic [2:0]  addr;
      logic [15:0] data;
      logic        rdy;
      logic        tk;
      logic [5:0]  sec;
   } vec_t;

   vec_t vt[12];

   function automatic vec_t mk(input bit irq, input bit cs, input bit wn,
                               input int a, input int d, input bit rdy,
                               input bit tk, input int s);
      vec_t v;
      v.irq  = irq;
      v.cs   = cs;
      v.wr_n = wn;
      v.addr = a[2:0];
      v.data = d[15:0];
      v.rdy  = rdy;
      v.tk   = tk;
      v.sec  = s[5:0];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_time(input string nm, input int h, input int m,
                           input int s);
      chk({nm, "_hour"}, 32'(hour), h);
      chk({nm, "_min"}, 32'(minute), m);
      chk({nm, "_sec"}, 32'(second), s);
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_cs"}, 32'(bus.tmr_chipselect), 0);
      chk({nm, "_wr_n"}, 32'(bus.tmr_write_n), 1);
      chk({nm, "_addr"}, 32'(bus.tmr_address), 0);
      chk({nm, "_data"}, 32'(bus.tmr_writedata), 0);
   endtask

   task automatic service();
      bus.tmr_irq = 1'b1;
      cyc();
      bus.tmr_irq = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic do_set(input int h, input int m);
      set_hour = h[4:0];
      set_min  = m[5:0];
      set_time = 1'b1;
      cyc();
      set_time = 1'b0;
   endtask

   task automatic wait_ready(input string nm);
      int k = 0;
      while (ready !== 1'b1 && k < 20) begin
         cyc();
         k++;
      end
      chk({nm, "_ready"}, 32'(ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = mk(0, 1, 0, 2, 16'hF07F, 0, 0, 0);
      vt[1]  = mk(0, 1, 0, 3, 16'h02FA, 0, 0, 0);
      vt[2]  = mk(0, 1, 0, 1, 16'h0007, 0, 0, 0);
      vt[3]  = mk(0, 0, 1, 0, 0, 1, 0, 0);
      vt[4]  = mk(1, 1, 0, 0, 0, 1, 0, 0);
      vt[5]  = mk(0, 0, 1, 0, 0, 1, 1, 0);
      vt[6]  = mk(0, 0, 1, 0, 0, 1, 0, 1);
      vt[7]  = mk(0, 0, 1, 0, 0, 1, 0, 1);
      vt[8]  = mk(1, 1, 0, 0, 0, 1, 0, 1);
      vt[9]  = mk(1, 0, 1, 0, 0, 1, 1, 1);
      vt[10] = mk(1, 0, 1, 0, 0, 1, 0, 2);
      vt[11] = mk(0, 0, 1, 0, 0, 1, 0, 2);

      bus.tmr_irq = 1'b0;
      repeat (3) cyc();
      chk_idle("rst");
      chk("rst_ready", 32'(ready), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_ring", 32'(ring), 0);
      chk_time("rst", 0, 0, 0);

      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus.tmr_irq = vt[i].irq;
         cyc();
         chk($sformatf("vec%0d_cs", i), 32'(bus.tmr_chipselect), 32'(vt[i].cs));
         chk($sformatf("vec%0d_wr_n", i), 32'(bus.tmr_write_n), 32'(vt[i].wr_n));
         chk($sformatf("vec%0d_addr", i), 32'(bus.tmr_address), 32'(vt[i].addr));
         chk($sformatf("vec%0d_data", i), 32'(bus.tmr_writedata), 32'(vt[i].data));
         chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(vt[i].rdy));
         chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vt[i].tk));
         chk($sformatf("vec%0d_sec", i), 32'(second), 32'(vt[i].sec));
      end
      bus.tmr_irq = 1'b0;

      // Out-of-range set requests are dropped with no bus activity.
      do_set(24, 10);
      chk_idle("bad_hour");
      chk("bad_hour_ready", 32'(ready), 1);
      chk_time("bad_hour", 0, 0, 2);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("bad_hour_cs%0d", i), 32'(bus.tmr_chipselect), 0);
      end
      do_set(5, 60);
      chk_idle("bad_min");
      chk_time("bad_min", 0, 0, 2);

      // set_time on the COUNT cycle.
      bus.tmr_irq = 1'b1;
      cyc();
      bus.tmr_irq = 1'b0;
      cyc();
      chk("collide_pre_tick", 32'(tick), 1);
      t0 = n_ticks;
      set_hour = 5'd7;
      set_min = 6'd30;
      set_time = 1'b1;
      #1;
      chk("collide_tick", 32'(tick), 0);
      cyc();
      set_time = 1'b0;
      chk_time("collide", 7, 30, 0);
      chk_idle("collide");
      chk("collide_ready", 32'(ready), 0);
      chk("collide_ticks", 32'(n_ticks - t0), 0);
      cyc();
      chk("restart_cs", 32'(bus.tmr_chipselect), 1);
      chk("restart_addr", 32'(bus.tmr_address), 2);
      chk("restart_data", 32'(bus.tmr_writedata), 32'h0000F07F);
      wait_ready("restart");

      // Reset in the middle of the init writes.
      do_set(1, 2);
      cyc();
      chk("midrst_pre_cs", 32'(bus.tmr_chipselect), 1);
      reset = 1'b1;
      cyc();
      chk_idle("midrst");
      chk("midrst_ready", 32'(ready), 0);
      chk_time("midrst", 0, 0, 0);
      reset = 1'b0;
      wait_ready("midrst");

      // Full-day rollover.
      do_set(23, 59);
      wait_ready("roll");
      t0 = n_ticks;
      repeat (59) service();
      chk_time("roll59", 23, 59, 59);
      service();
      chk_time("roll", 0, 0, 0);
      chk("roll_ticks", 32'(n_ticks - t0), 60);

      // Alarm with acknowledge.
      alarm_en = 1'b1;
      alarm_hour = 5'd7;
      alarm_min = 6'd31;
      do_set(7, 30);
      wait_ready("alm");
      repeat (59) service();
      chk("alm_pre_ring", 32'(ring), 0);
      service();
      chk_time("alm", 7, 31, 0);
      chk("alm_ring", 32'(ring), ALM);
      alarm_ack = 1'b1;
      cyc();
      alarm_ack = 1'b0;
      chk("alm_ack_ring", 32'(ring), 0);

      // Alarm left ringing until the duration limit.
      do_set(7, 30);
      wait_ready("alm2");
      repeat (60) service();
      chk("alm2_ring", 32'(ring), ALM);
      repeat (59) service();
      chk_time("alm2_59", 7, 31, 59);
      chk("alm2_ring59", 32'(ring), ALM);
      service();
      chk("alm2_ring60", 32'(ring), 0);
      chk_time("alm2_60", 7, 32, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
